multicycle_control_fsm: RTL and testbench

Multicycle control unit for the RV64 datapath: PC, instruction register, register bank, A/B registers, ALU, ALU-input muxes and data memory. A Moore FSM sequences fetch, decode, execute, memory and write-back, with one Mealy term for the branch decision. It replaces the ad-hoc control unit and adds load/store, branch, LUI support and configurable memory latency.

---
 rtl/multicycle_control_fsm.sv | 211 +++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Multicycle control unit for the RV64 datapath: fetch/decode/execute/memory/write-back sequencing.
// Optional build macro ILLEGAL_TRAP_EN: unknown opcodes trap instead of executing as a NOP.
module multicycle_control_fsm #(
  parameter int MEM_LAT = 1,
  parameter int ALU_W   = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7_b5,
  input  logic             alu_zero,
  output logic             pc_write,
  output logic             pc_src,
  output logic             load_ir,
  output logic             regs_ab_load,
  output logic             aluout_load,
  output logic             mdr_load,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic [2:0]       mux_a_sel,
  output logic [2:0]       mux_b_sel,
  output logic [ALU_W-1:0] alu_sel,
  output logic             dmem_wr,
  output logic             trap,
  output logic [3:0]       state_o
);

  // state    | meaning
  // FETCH    | wait MEM_LAT cycles for instruction, load IR, PC += 4
  // DECODE   | load A/B, speculative branch target into ALUOut
  // EXEC_R   | register-register ALU op
  // EXEC_I   | register-immediate ALU op
  // WB_ALU   | write ALUOut to register bank
  // MEM_ADDR | compute load/store address
  // MEM_RD   | wait MEM_LAT cycles for data, load MDR
  // WB_MEM   | write MDR to register bank
  // MEM_WR   | single-cycle data memory write
  // BRANCH   | compare A-B, conditionally load PC from ALUOut
  // WB_LUI   | write U-immediate to register bank
  // TRAP     | illegal instruction, held until reset
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    WB_ALU   = 4'd4,
    MEM_ADDR = 4'd5,
    MEM_RD   = 4'd6,
    WB_MEM   = 4'd7,
    MEM_WR   = 4'd8,
    BRANCH   = 4'd9,
    WB_LUI   = 4'd10,
    TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [ALU_W-1:0] ALU_ADD = ALU_W'(0);
  localparam logic [ALU_W-1:0] ALU_SUB = ALU_W'(1);
  localparam logic [ALU_W-1:0] ALU_AND = ALU_W'(2);
  localparam logic [ALU_W-1:0] ALU_OR  = ALU_W'(3);
  localparam logic [ALU_W-1:0] ALU_XOR = ALU_W'(4);
  localparam logic [ALU_W-1:0] ALU_SLT = ALU_W'(5);

  localparam logic [2:0] WAIT_LAST = 3'(MEM_LAT - 1);

  state_t     state, state_next;
  logic [2:0] wait_cnt;
  logic       wait_done;

  assign wait_done = (wait_cnt == WAIT_LAST);

  function automatic logic [ALU_W-1:0] alu_decode(input logic [2:0] f3, input logic sub_en);
    case (f3)
      3'b000:  return sub_en ? ALU_SUB : ALU_ADD;
      3'b111:  return ALU_AND;
      3'b110:  return ALU_OR;
      3'b100:  return ALU_XOR;
      3'b010:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  // Counter only advances while waiting on memory; any state change restarts it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= FETCH;
      wait_cnt <= '0;
    end else begin
      state <= state_next;
      if (state_next != state || wait_done)
        wait_cnt <= '0;
      else
        wait_cnt <= wait_cnt + 3'd1;
    end
  end

  always_comb begin
    state_next   = state;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    load_ir      = 1'b0;
    regs_ab_load = 1'b0;
    aluout_load  = 1'b0;
    mdr_load     = 1'b0;
    reg_write    = 1'b0;
    wb_sel       = 2'd0;
    mux_a_sel    = 3'd0;
    mux_b_sel    = 3'd0;
    alu_sel      = ALU_ADD;
    dmem_wr      = 1'b0;
    trap         = 1'b0;
    if (!reset) begin
      case (state)
        FETCH: begin
          if (wait_done) begin
            load_ir    = 1'b1;
            pc_write   = 1'b1;
            mux_b_sel  = 3'd1;
            state_next = DECODE;
          end
        end
        DECODE: begin
          regs_ab_load = 1'b1;
          aluout_load  = 1'b1;
          mux_a_sel    = 3'd2;
          mux_b_sel    = 3'd2;
          case (opcode)
            OP_R:               state_next = EXEC_R;
            OP_I:               state_next = EXEC_I;
            OP_LOAD, OP_STORE:  state_next = MEM_ADDR;
            OP_BRANCH:          state_next = BRANCH;
            OP_LUI:             state_next = WB_LUI;
`ifdef ILLEGAL_TRAP_EN
            default:            state_next = TRAP;
`else
            default:            state_next = FETCH;
`endif
          endcase
        end
        EXEC_R: begin
          mux_a_sel   = 3'd1;
          aluout_load = 1'b1;
          alu_sel     = alu_decode(funct3, funct7_b5);
          state_next  = WB_ALU;
        end
        EXEC_I: begin
          mux_a_sel   = 3'd1;
          mux_b_sel   = 3'd2;
          aluout_load = 1'b1;
          alu_sel     = alu_decode(funct3, 1'b0);
          state_next  = WB_ALU;
        end
        WB_ALU: begin
          reg_write  = 1'b1;
          state_next = FETCH;
        end
        MEM_ADDR: begin
          mux_a_sel   = 3'd1;
          mux_b_sel   = 3'd2;
          aluout_load = 1'b1;
          state_next  = (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
        end
        MEM_RD: begin
          if (wait_done) begin
            mdr_load   = 1'b1;
            state_next = WB_MEM;
          end
        end
        WB_MEM: begin
          reg_write  = 1'b1;
          wb_sel     = 2'd1;
          state_next = FETCH;
        end
        MEM_WR: begin
          dmem_wr    = 1'b1;
          state_next = FETCH;
        end
        BRANCH: begin
          // Mealy term: the branch decision follows alu_zero within the cycle.
          mux_a_sel  = 3'd1;
          alu_sel    = ALU_SUB;
          pc_src     = 1'b1;
          pc_write   = ((funct3 == 3'b000) && alu_zero) || ((funct3 == 3'b001) && !alu_zero);
          state_next = FETCH;
        end
        WB_LUI: begin
          reg_write  = 1'b1;
          wb_sel     = 2'd2;
          state_next = FETCH;
        end
        TRAP: begin
`ifdef ILLEGAL_TRAP_EN
          trap = 1'b1;
`endif
          state_next = TRAP;
        end
        default: state_next = FETCH;
      endcase
    end
  end

  assign state_o = reset ? 4'd0 : state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: two instances (MEM_LAT=1 and 3) checked cycle by cycle against per-instruction schedules.
module tb_multicycle_control_fsm;

  localparam int N = 2;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, pcs, lir, abl, aol, mdr, rw;
    logic [1:0] wb;
    logic [2:0] ma, mb, alu;
    logic       dw, tr;
  } cyc_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       rst [N];
  logic [6:0] op  [N];
  logic [2:0] f3  [N];
  logic       b5  [N];
  logic       zf  [N];
  logic       pcw [N], pcs [N], lir [N], abl [N], aol [N], mdr [N], rw [N], dw [N], tr [N];
  logic [1:0] wb  [N];
  logic [2:0] ma  [N], mb [N], alu [N];
  logic [3:0] st  [N];

  int n_chk  = 0;
  int n_pass = 0;

  for (genvar g = 0; g < N; g++) begin : g_dut
    multicycle_control_fsm #(.MEM_LAT(g == 0 ? 1 : 3), .ALU_W(3)) u_dut (
      .clock(clock), .reset(rst[g]), .opcode(op[g]), .funct3(f3[g]),
      .funct7_b5(b5[g]), .alu_zero(zf[g]),
      .pc_write(pcw[g]), .pc_src(pcs[g]), .load_ir(lir[g]), .regs_ab_load(abl[g]),
      .aluout_load(aol[g]), .mdr_load(mdr[g]), .reg_write(rw[g]), .wb_sel(wb[g]),
      .mux_a_sel(ma[g]), .mux_b_sel(mb[g]), .alu_sel(alu[g]), .dmem_wr(dw[g]),
      .trap(tr[g]), .state_o(st[g])
    );
  end

  function automatic cyc_t obs(input int d);
    return {st[d], pcw[d], pcs[d], lir[d], abl[d], aol[d], mdr[d], rw[d],
            wb[d], ma[d], mb[d], alu[d], dw[d], tr[d]};
  endfunction

  function automatic logic [2:0] alu_of(input logic [2:0] f, input logic sub, input logic is_r);
    case (f)
      3'b000:  return (is_r && sub) ? 3'd1 : 3'd0;
      3'b111:  return 3'd2;
      3'b110:  return 3'd3;
      3'b100:  return 3'd4;
      3'b010:  return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

  // Runs one instruction on instance d starting at a negedge in the first FETCH cycle.
  // abort_at: cycle index at which reset is raised (-1 = none).
  task automatic run_instr(input int d, input logic [6:0] o, input logic [2:0] fn3,
                           input logic sub, input logic z, input int abort_at, input bit fresh);
    cyc_t q[$];
    cyc_t c;
    int   lat;
    int   ab;
    bit   illegal;
    lat = (d == 0) ? 1 : 3;
    ab = abort_at;
    illegal = 0;
    c = '0;
    for (int i = 0; i < lat - 1; i++) q.push_back(c);
    c.lir = 1; c.pcw = 1; c.mb = 3'd1; q.push_back(c);
    c = '0; c.st = 4'd1; c.abl = 1; c.aol = 1; c.ma = 3'd2; c.mb = 3'd2; q.push_back(c);
    case (o)
      7'b0110011: begin
        c = '0; c.st = 4'd2; c.ma = 3'd1; c.aol = 1; c.alu = alu_of(fn3, sub, 1'b1); q.push_back(c);
        c = '0; c.st = 4'd4; c.rw = 1; q.push_back(c);
      end
      7'b0010011: begin
        c = '0; c.st = 4'd3; c.ma = 3'd1; c.mb = 3'd2; c.aol = 1; c.alu = alu_of(fn3, sub, 1'b0); q.push_back(c);
        c = '0; c.st = 4'd4; c.rw = 1; q.push_back(c);
      end
      7'b0000011: begin
        c = '0; c.st = 4'd5; c.ma = 3'd1; c.mb = 3'd2; c.aol = 1; q.push_back(c);
        c = '0; c.st = 4'd6;
        for (int i = 0; i < lat - 1; i++) q.push_back(c);
        c.mdr = 1; q.push_back(c);
        c = '0; c.st = 4'd7; c.rw = 1; c.wb = 2'd1; q.push_back(c);
      end
      7'b0100011: begin
        c = '0; c.st = 4'd5; c.ma = 3'd1; c.mb = 3'd2; c.aol = 1; q.push_back(c);
        c = '0; c.st = 4'd8; c.dw = 1; q.push_back(c);
      end
      7'b1100011: begin
        c = '0; c.st = 4'd9; c.ma = 3'd1; c.alu = 3'd1; c.pcs = 1;
        c.pcw = (fn3 == 3'b000 && z) || (fn3 == 3'b001 && !z);
        q.push_back(c);
      end
      7'b0110111: begin
        c = '0; c.st = 4'd10; c.rw = 1; c.wb = 2'd2; q.push_back(c);
      end
      default: begin
        illegal = 1;
`ifdef ILLEGAL_TRAP_EN
        c = '0; c.st = 4'd15; c.tr = 1;
        for (int i = 0; i < 3; i++) q.push_back(c);
`endif
      end
    endcase
`ifdef ILLEGAL_TRAP_EN
    if (illegal && (ab < 0 || ab > q.size())) ab = q.size();
`endif
    if (fresh) begin
      rst[d] = 1'b1;
      #1;
      n_chk++;
      if (obs(d) !== cyc_t'(0)) $display("FAIL reset_hold d=%0d got=%h exp=%h", d, obs(d), cyc_t'(0));
      else n_pass++;
      @(negedge clock);
    end
    rst[d] = 1'b0; op[d] = o; f3[d] = fn3; b5[d] = sub; zf[d] = z;
    for (int i = 0; i < q.size(); i++) begin
      if (i == ab) break;
      #1;
      n_chk++;
      if (obs(d) !== q[i])
        $display("FAIL seq d=%0d op=%b f3=%b cyc=%0d got=%h exp=%h", d, o, fn3, i, obs(d), q[i]);
      else n_pass++;
      @(negedge clock);
    end
    if (ab >= 0 && ab <= q.size()) begin
      rst[d] = 1'b1;
      #1;
      n_chk++;
      if (obs(d) !== cyc_t'(0))
        $display("FAIL abort d=%0d op=%b cyc=%0d got=%h exp=%h", d, o, ab, obs(d), cyc_t'(0));
      else n_pass++;
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < N; d++) begin
      rst[d] = 1'b1; op[d] = '0; f3[d] = '0; b5[d] = 1'b0; zf[d] = 1'b0;
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    #1;
    for (int d = 0; d < N; d++) begin
      n_chk++;
      if (obs(d) !== cyc_t'(0)) $display("FAIL reset d=%0d got=%h exp=%h", d, obs(d), cyc_t'(0));
      else n_pass++;
    end
    @(negedge clock);
    run_instr(0, 7'b0010011, 3'b000, 1'b1, 1'b0, -1, 0);
  endtask

  task automatic test_r_type();
    run_instr(0, 7'b0110011, 3'b000, 1'b1, 1'b0, -1, 1);
    run_instr(0, 7'b0110011, 3'b111, 1'b0, 1'b0, -1, 0);
    run_instr(0, 7'b0110011, 3'b001, 1'b1, 1'b0, -1, 0);
    run_instr(1, 7'b0110011, 3'b010, 1'b0, 1'b0, -1, 1);
  endtask

  task automatic test_load_lat3();
    run_instr(1, 7'b0000011, 3'b011, 1'b0, 1'b0, -1, 1);
    run_instr(0, 7'b0000011, 3'b011, 1'b0, 1'b0, -1, 1);
  endtask

  task automatic test_branch();
    run_instr(0, 7'b1100011, 3'b000, 1'b0, 1'b1, -1, 1);
    run_instr(0, 7'b1100011, 3'b000, 1'b0, 1'b0, -1, 0);
    run_instr(0, 7'b1100011, 3'b001, 1'b0, 1'b0, -1, 0);
    run_instr(0, 7'b1100011, 3'b001, 1'b0, 1'b1, -1, 0);
    run_instr(0, 7'b1100011, 3'b100, 1'b0, 1'b1, -1, 0);
  endtask

  task automatic test_store_reset();
    run_instr(0, 7'b0100011, 3'b011, 1'b0, 1'b0, -1, 1);
    run_instr(0, 7'b0100011, 3'b011, 1'b0, 1'b0, 2, 0);
    run_instr(0, 7'b0110111, 3'b000, 1'b0, 1'b0, -1, 0);
    run_instr(1, 7'b0000011, 3'b000, 1'b0, 1'b0, 5, 1);
    run_instr(1, 7'b0110111, 3'b000, 1'b0, 1'b0, -1, 0);
  endtask

  task automatic test_illegal();
    run_instr(0, 7'b1111111, 3'b000, 1'b0, 1'b0, -1, 1);
    run_instr(0, 7'b0010011, 3'b100, 1'b0, 1'b0, -1, 0);
    run_instr(1, 7'b1111111, 3'b000, 1'b0, 1'b0, -1, 1);
    run_instr(1, 7'b0110011, 3'b110, 1'b0, 1'b0, -1, 0);
  endtask

  task automatic rand_stream(input int d, input int n);
    logic [6:0] o;
    logic [2:0] fn3;
    int         ab;
    for (int k = 0; k < n; k++) begin
      fn3 = 3'($urandom);
      case ($urandom_range(0, 6))
        0: o = 7'b0110011;
        1: o = 7'b0010011;
        2: o = 7'b0000011;
        3: o = 7'b0100011;
        4: begin
          o = 7'b1100011;
          if ($urandom_range(0, 3) != 0) fn3 = {2'b00, 1'($urandom)};
        end
        5: o = 7'b0110111;
        default: o = ($urandom_range(0, 1) == 0) ? 7'b1110011 : 7'b0000000;
      endcase
      ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 5)) : -1;
      run_instr(d, o, fn3, 1'($urandom), 1'($urandom), ab, k == 0);
    end
  endtask

  task automatic test_back_to_back();
    fork
      rand_stream(0, 60);
      rand_stream(1, 40);
    join
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout after 2000000 time units");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_r_type();
    test_load_lat3();
    test_branch();
    test_store_reset();
    test_illegal();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
